// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB first, optional
// parity bit and SB_TICK/16 stop bits, paced by a 16x oversampling tick.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx is registered, so it is loaded with the level of the state being entered
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        n_d     = '0;
                        p_d     = (PARITY == 1);
                        tx_d    = b_q[0];
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        p_d = p_q ^ b_q[0];
                        if (n_q == NW'(DBIT - 1)) begin
                            if (PARITY != 0) begin
                                tx_d    = p_q ^ b_q[0];
                                state_d = PAR;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = STOP;
                            end
                        end else begin
                            n_d  = n_q + 1'b1;
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no, odd, even parity) checked
// against a frame-level bit-list model with a 4-clock tick spacing.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [2:0] tx_start;
    logic [7:0] din [3];
    logic [2:0] tx_w, busy_w, done_w;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;
    bit tick_rand = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
        .clk(clk), .reset(reset), .tx_start(tx_start[0]), .s_tick(s_tick),
        .din(din[0]), .tx_done_tick(done_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
        .clk(clk), .reset(reset), .tx_start(tx_start[1]), .s_tick(s_tick),
        .din(din[1]), .tx_done_tick(done_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
        .clk(clk), .reset(reset), .tx_start(tx_start[2]), .s_tick(s_tick),
        .din(din[2]), .tx_done_tick(done_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));

    // s_tick every 4 clocks (or random), changed 2ns after each rising edge
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tick_rand) begin
                s_tick = 1'($urandom % 2);
            end else begin
                tick_cnt = (tick_cnt + 1) % 4;
                s_tick = (tick_cnt == 0);
            end
        end
    end

    // Frame as a list of line levels: start, data LSB first, parity, stop
    function automatic int model(input int par, input logic [7:0] d,
                                 output logic [11:0] bits);
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) bits[1+b] = d[b];
        n = 9;
        if (par != 0) begin
            bits[n] = (^d) ^ (par == 1);
            n++;
        end
        bits[n] = 1'b1;
        return n + 1;
    endfunction

    // Raise tx_start so it is sampled on an edge that also carries s_tick
    task automatic accept(input int i, input logic [7:0] d);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (s_tick) break;
        end
        tx_start[i] = 1'b1;
        din[i] = d;
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after the accepting edge; ends 1ns after the done edge
    task automatic check_frame(input int i, input logic [7:0] d,
                               input int first_len, input int inject_j);
        logic [11:0] bits;
        int nb, total, done_cnt, bs, be;
        nb = model(i, d, bits);
        total = first_len + 64 * (nb - 1);
        done_cnt = 0;
        for (int j = 0; j <= total; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (j == inject_j) begin
                tx_start[i] = 1'b1;
                din[i] = 8'hFF;
            end
            if (inject_j >= 0 && j == inject_j + 1) tx_start[i] = 1'b0;
            if (j < total && done_w[i]) done_cnt++;
            if (j == 0) begin
                checks++;
                if (busy_w[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_accept u%0d: busy=%b expected 1", i, busy_w[i]);
                end
            end
            for (int b = 0; b < nb; b++) begin
                bs = (b == 0) ? 0 : first_len + 64 * (b - 1);
                be = first_len + 64 * b - 1;
                if (j == bs || j == be) begin
                    checks++;
                    if (tx_w[i] !== bits[b]) begin
                        errors++;
                        $display("FAIL frame_bit u%0d bit%0d j=%0d: tx=%b expected %b",
                                 i, b, j, tx_w[i], bits[b]);
                    end
                end
            end
        end
        checks++;
        if (done_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || tx_w[i] !== 1'b1) begin
            errors++;
            $display("FAIL frame_end u%0d: done=%b busy=%b tx=%b expected 1 0 1",
                     i, done_w[i], busy_w[i], tx_w[i]);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL early_done u%0d: %0d pulses expected 0", i, done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick_rand = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tx_start = 3'($urandom);
            for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (tx_w !== 3'b111 || busy_w !== 3'b000 || done_w !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold c=%0d: tx=%b busy=%b done=%b expected 111 000 000",
                         c, tx_w, busy_w, done_w);
            end
        end
        tx_start = 3'b000;
        tick_rand = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        accept(0, 8'hA5);
        tx_start[0] = 1'b0;
        check_frame(0, 8'hA5, 64, -1);
        d = 8'($urandom);
        accept(0, d);
        tx_start[0] = 1'b0;
        din[0] = ~d;
        check_frame(0, d, 64, -1);
    endtask

    task automatic test_parity();
        logic [7:0] d;
        for (int i = 2; i >= 1; i--) begin
            accept(i, 8'h07);
            tx_start[i] = 1'b0;
            check_frame(i, 8'h07, 64, -1);
            d = 8'($urandom);
            accept(i, d);
            tx_start[i] = 1'b0;
            check_frame(i, d, 64, -1);
        end
    endtask

    task automatic test_ignored_request();
        logic [7:0] d;
        int extra;
        d = 8'($urandom) & 8'h7F;
        accept(0, d);
        tx_start[0] = 1'b0;
        check_frame(0, d, 64, 64 * 3 + 10);
        extra = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (busy_w[0] || !tx_w[0]) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL no_second_frame: %0d busy cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        accept(0, 8'h00);
        din[0] = 8'hFF;
        check_frame(0, 8'h00, 64, -1);
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        check_frame(0, 8'hFF, 63, -1);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int bad;
        d = 8'($urandom);
        accept(0, d);
        tx_start[0] = 1'b0;
        for (int j = 1; j <= 64 * 4 + 20; j++) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx=%b busy=%b expected 1 0", tx_w[0], busy_w[0]);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || !tx_w[0]) bad++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0] || !tx_w[0]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_abandon: %0d bad cycles expected 0", bad);
        end
        d = 8'($urandom);
        accept(0, d);
        tx_start[0] = 1'b0;
        check_frame(0, d, 64, -1);
    endtask

    initial begin
        tx_start = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
